// File: rtl/retry_pkg.sv
// Shared types for the in-order retry endpoint: routing state and attempt-counter sizing.
package retry_pkg;

    typedef enum logic {
        PASS  = 1'b0,
        DRAIN = 1'b1
    } retry_state_e;

    // One extra code point so the counter can hold MaxRetries itself; at least 1 bit.
    function automatic int unsigned attempts_width(input int unsigned max_retries);
        return (max_retries == 0) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/retry_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module retry_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + Width'(1);
        end
    end

endmodule

// File: rtl/retry_inorder_bounded_end.sv
// In-order retry endpoint: diverts failed items and their successors to retry until the
// failed item returns, aborting after MaxRetries. RETRY_INORDER_STATS_EN adds counters.
module retry_inorder_bounded_end
    import retry_pkg::*;
#(
    parameter type         DataType   = logic,
    parameter int unsigned IDSize     = 1,
    parameter int unsigned MaxRetries = 3,
    parameter int unsigned CntWidth   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              needs_retry_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic              error_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [IDSize-1:0] retry_id_o,
    output logic              retry_valid_o,
    input  logic              retry_ready_i,
    input  logic [IDSize-1:0] retry_id_feedback_i,
    output logic              retry_lock_o
`ifdef RETRY_INORDER_STATS_EN
    ,
    output logic [CntWidth-1:0] retry_cnt_o,
    output logic [CntWidth-1:0] abort_cnt_o
`endif
);

    localparam int unsigned AttW = attempts_width(MaxRetries);
    localparam logic [AttW-1:0] MaxAtt = AttW'(MaxRetries);

    retry_state_e      state_q, state_d;
    logic [IDSize-1:0] failed_id_q, failed_id_d;
    logic [AttW-1:0]   attempts_q, attempts_d;
    logic              divert, retry_req, abort, accept;

    assign data_o     = data_i;
    assign retry_id_o = id_i;

    always_comb begin
        state_d     = state_q;
        failed_id_d = failed_id_q;
        attempts_d  = attempts_q;
        divert      = 1'b0;
        retry_req   = 1'b0;
        abort       = 1'b0;

        // While draining, everything behind the failed item goes back for retry.
        if ((state_q == DRAIN) && (id_i != failed_id_q)) begin
            divert = 1'b1;
        end else if (needs_retry_i) begin
            if (attempts_q < MaxAtt) begin
                divert    = 1'b1;
                retry_req = 1'b1;
            end else begin
                abort = 1'b1;
            end
        end

        valid_o       = divert ? 1'b0 : valid_i;
        error_o       = valid_i & abort;
        ready_o       = divert ? retry_ready_i : ready_i;
        retry_valid_o = divert ? valid_i : 1'b0;
        retry_lock_o  = divert | (state_q == DRAIN);
        accept        = valid_i & ready_o;

        if (accept) begin
            if (retry_req) begin
                state_d     = DRAIN;
                failed_id_d = retry_id_feedback_i;
                attempts_d  = (retry_id_feedback_i == failed_id_q) ? attempts_q + AttW'(1)
                                                                   : AttW'(1);
            end else if (!divert) begin
                state_d = PASS;
                if ((id_i == failed_id_q) || abort) begin
                    attempts_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= PASS;
            failed_id_q <= '0;
            attempts_q  <= '0;
        end else begin
            state_q     <= state_d;
            failed_id_q <= failed_id_d;
            attempts_q  <= attempts_d;
        end
    end

`ifdef RETRY_INORDER_STATS_EN
    logic retry_inc, abort_inc;

    assign retry_inc = accept & retry_req;
    assign abort_inc = accept & abort;

    retry_sat_counter #(.Width(CntWidth)) u_retry_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (retry_inc),
        .cnt_o (retry_cnt_o)
    );

    retry_sat_counter #(.Width(CntWidth)) u_abort_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (abort_inc),
        .cnt_o (abort_cnt_o)
    );
`else
    // Statistics disabled: no counter state.
`endif

endmodule

// File: doc/retry_inorder_bounded_end.md
RETRY_INORDER_BOUNDED_END -- requirements
Module: retry_inorder_bounded_end

Interface
REQ-001 SHALL have parameter DataType, default logic, payload type passed through unchanged.
REQ-002 SHALL have parameter IDSize, default 1, width of item IDs.
REQ-003 SHALL have parameter MaxRetries, default 3, retries allowed per item before abort; 0 means never retry.
REQ-004 SHALL have parameter CntWidth, default 16, width of statistics counters.
REQ-005 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have upstream ports: data_i  in  DataType; id_i  in  IDSize; needs_retry_i  in  1  item failed check; valid_i  in  1; ready_o  out  1.
REQ-007 SHALL have downstream ports: data_o  out  DataType; error_o  out  1  item aborted after MaxRetries; valid_o  out  1; ready_i  in  1.
REQ-008 SHALL have retry ports: retry_id_o  out  IDSize; retry_valid_o  out  1; retry_ready_i  in  1; retry_id_feedback_i  in  IDSize  ID restarted by retry start; retry_lock_o  out  1  holds retry start's new-issue path.
REQ-009 SHALL have, only with RETRY_INORDER_STATS_EN, ports retry_cnt_o  out  CntWidth and abort_cnt_o  out  CntWidth.

Function
REQ-010 SHALL drive data_o = data_i and retry_id_o = id_i combinationally at all times.
REQ-011 SHALL implement states PASS and DRAIN; "accept" means valid_i & ready_o.
REQ-012 SHALL compute combinational route: DRAIN with id_i != failed_id_q -> divert; otherwise evaluate PASS rules on the current item (matching item re-checked, including needs_retry_i).
REQ-013 SHALL, in PASS rules: needs_retry_i=0 -> forward; needs_retry_i=1 and attempts < MaxRetries -> divert and request retry; needs_retry_i=1 and attempts == MaxRetries -> forward with error_o=1.
REQ-014 SHALL, when forwarding, set valid_o=valid_i, ready_o=ready_i, retry_valid_o=0; when diverting, set retry_valid_o=valid_i, ready_o=retry_ready_i, valid_o=0.
REQ-015 SHALL assert retry_lock_o whenever route is divert or state is DRAIN, independent of valid_i.
REQ-016 SHALL update state only on accept; no accept -> all registers hold.
REQ-017 SHALL, on accept of a retry request, go to DRAIN, load failed_id_q = retry_id_feedback_i, increment attempts_q if feedback equals previous failed_id_q else set attempts_q = 1.
REQ-018 SHALL, on accept of forwarded matching-or-PASS item, go/stay PASS; clear attempts_q if id_i == failed_id_q or error_o was 1.
REQ-019 SHALL size attempts_q as $clog2(MaxRetries+1), minimum 1 bit; never exceeds MaxRetries.
REQ-020 SHALL hold error_o=0 whenever valid_o=0.
REQ-021 SHALL have zero latency (fully combinational data/handshake path); no storage of payloads.

Reset
REQ-022 SHALL reset to PASS, failed_id_q=0, attempts_q=0, counters=0 on the clock edge where rst_i=1.
REQ-023 SHALL, on reset mid-DRAIN, forget the failed ID; outputs follow PASS rules from the cycle after reset; reset outputs are valid_o=valid_i, retry_valid_o=0, retry_lock_o=0 when no item fails.

Configuration
REQ-024 SHALL, with RETRY_INORDER_STATS_EN defined, count accepted retry requests (retry_cnt_o) and accepted aborts (abort_cnt_o), saturating at all-ones.
REQ-025 SHALL, without RETRY_INORDER_STATS_EN, omit counter ports and registers; function otherwise identical.

Structure
REQ-026 SHALL place the state enum (PASS, DRAIN) and an attempts-width function in shared package retry_pkg.
REQ-027 SHALL implement counters in sub-module retry_sat_counter (width param, sync-high reset, inc, saturating).

Verification
REQ-028 SHALL test: IDs 0,1,2,3 all pass, ready_i=1 -> valid_o 4 cycles, retry_valid_o never, error_o=0.
REQ-029 SHALL test: ID1 fails (feedback 1), then 2,3 arrive -> 1,2,3 diverted, lock high; retried 1 passes -> forwarded, PASS, order 0,1,2,3 downstream.
REQ-030 SHALL test: MaxRetries=2, ID5 fails 3 consecutive times -> 2 retries, third forwarded with error_o=1, attempts cleared, abort_cnt_o=1, retry_cnt_o=2.
REQ-031 SHALL test: retry_ready_i=0 while diverting -> ready_o=0, state and failed_id_q held for 5 cycles.
REQ-032 SHALL test: rst_i=1 during DRAIN -> next cycle PASS, incoming ID7 forwarded, counters 0.
REQ-033 SHALL test: MaxRetries=0, ID2 fails -> forwarded with error_o=1, no retry_valid_o.
